// File: rtl/fifo_reader.sv
// FIFO-to-stream reader: pops an upstream FIFO into a 2-entry skid buffer and emits framed words.
// Optional feature: define FIFO_READER_PARITY_EN to drive outParity with the even parity of outData.
module fifo_reader #(
  parameter int unsigned DataWidth = 64,
  parameter int unsigned FrameLen  = 16
) (
  input  logic                 clk,
  input  logic                 rstN,
  input  logic                 fifoEmpty,
  input  logic [DataWidth-1:0] fifoReadData,
  output logic                 fifoReadEn,
  input  logic                 enable,
  output logic                 outValid,
  input  logic                 outReady,
  output logic [DataWidth-1:0] outData,
  output logic                 outLast,
  output logic                 outParity,
  output logic [15:0]          wordCount
);

  localparam int unsigned CntW = 16;
  localparam logic [CntW-1:0] LastBeat = CntW'(FrameLen - 1);

  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] ONE   = 2'd1;
  localparam logic [1:0] TWO   = 2'd2;

  logic [1:0]           state_q, state_d;
  logic [DataWidth-1:0] head_q, head_d;
  logic [DataWidth-1:0] tail_q, tail_d;
  logic [CntW-1:0]      beat_q, beat_d;
  logic [CntW-1:0]      wcnt_q, wcnt_d;

  logic pop;
  logic xfer;

  // Pop only while a buffer slot is guaranteed free; independent of outReady.
  assign fifoReadEn = enable & ~fifoEmpty & (state_q != TWO) & rstN;
  assign pop        = fifoReadEn;
  assign outValid   = (state_q != EMPTY);
  assign xfer       = outValid & outReady;
  assign outData    = head_q;
  assign outLast    = outValid & (beat_q == LastBeat);
  assign wordCount  = wcnt_q;

`ifdef FIFO_READER_PARITY_EN
  assign outParity = ^head_q;
`else
  assign outParity = 1'b0;
`endif

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q <= EMPTY;
      head_q  <= '0;
      tail_q  <= '0;
      beat_q  <= '0;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      beat_q  <= beat_d;
      wcnt_q  <= wcnt_d;
    end
  end

  // Skid-buffer occupancy and entry movement.
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    case (state_q)
      EMPTY: begin
        if (pop) begin
          head_d  = fifoReadData;
          state_d = ONE;
        end
      end
      ONE: begin
        if (pop && xfer) begin
          head_d = fifoReadData;
        end else if (pop) begin
          tail_d  = fifoReadData;
          state_d = TWO;
        end else if (xfer) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        if (xfer) begin
          head_d  = tail_q;
          state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // Frame beat and total word counters advance per output transfer.
  always_comb begin
    beat_d = beat_q;
    wcnt_d = wcnt_q;
    if (xfer) begin
      beat_d = (beat_q == LastBeat) ? '0 : beat_q + CntW'(1);
      wcnt_d = wcnt_q + CntW'(1);
    end
  end

endmodule
